// File: rtl/line_fetch_buffer.sv
// rtl/line_fetch_buffer.sv - scanline prefetch client of the SDRAM arbiter with ping-pong line buffer
//
// Purpose:
//   At the end of each scanline (DrawX reaching TRIGGER_X) fetches the next
//   visible line from the SDRAM framebuffer (WPL 128-bit words, 8 RGB565
//   pixels each) into the non-displayed half of a two-bank line buffer, and
//   serves the displayed half to the colour path indexed by DrawX.
//
// Optional feature macro: LB_UNDERRUN_STAT_EN
//   defined   - underrun_cnt counts dropped triggers, saturating at 255
//   undefined - no counter is built, underrun_cnt is tied to 0
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   DrawX, DrawY   in   current pixel column / line
//   lb_sdram_rd    out  read request to arbiter
//   lb_sdram_addr  out  word address of the request
//   lb_sdram_Wait  in   arbiter not granting this client
//   lb_sdram_ac    in   one-cycle acknowledge, data valid same cycle
//   lb_sdram_data  in   128-bit read data, pixel 0 in [15:0]
//   lb_Busy        out  fetch in progress
//   lb_done        out  last visible line of the frame fetched
//   pix_data       out  registered RGB565 pixel for DrawX/DrawY
//   underrun_cnt   out  saturating dropped-trigger count

module line_fetch_buffer #(
    parameter logic [21:0] FB_BASE   = 22'h000000,
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_TOTAL   = 525,
    parameter int          TRIGGER_X = 799
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [9:0]   DrawX,
    input  logic [9:0]   DrawY,
    output logic         lb_sdram_rd,
    output logic [21:0]  lb_sdram_addr,
    input  logic         lb_sdram_Wait,
    input  logic         lb_sdram_ac,
    input  logic [127:0] lb_sdram_data,
    output logic         lb_Busy,
    output logic         lb_done,
    output logic [15:0]  pix_data,
    output logic [7:0]   underrun_cnt
);

    localparam int WPL = H_ACTIVE / 8;
    localparam int WW  = $clog2(WPL);
    localparam int AW  = $clog2(2 * WPL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_REQ  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          trig_prev;
    logic          trigger;
    logic          has_target;
    logic [9:0]    target_line;
    logic          start;
    logic          ac_hit;
    logic          last_ac;

    logic          disp_bank;
    logic [WW-1:0] word;
    logic [21:0]   base;
    logic [9:0]    line;

    logic [127:0]  buf_mem [0:2*WPL-1];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          visible;
    logic [127:0]  rd_word;

    // Edge detect so a DrawX held at TRIGGER_X for several clk fires once.
    assign trigger = (DrawX == 10'(TRIGGER_X)) && !trig_prev;

    // Line following the current one; the last line of the frame wraps to
    // line 0, and the blanking lines before it request nothing.
    always_comb begin
        has_target  = 1'b0;
        target_line = 10'd0;
        if (DrawY == 10'(V_TOTAL - 1)) begin
            has_target  = 1'b1;
            target_line = 10'd0;
        end else if (DrawY < 10'(V_ACTIVE - 1)) begin
            has_target  = 1'b1;
            target_line = DrawY + 10'd1;
        end
    end

    assign start   = trigger && has_target && (state == S_IDLE);
    assign ac_hit  = (state == S_REQ) && lb_sdram_ac;
    assign last_ac = ac_hit && (word == WW'(WPL - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!lb_sdram_Wait) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (lb_sdram_ac) begin
                    if (word == WW'(WPL - 1)) begin
                        state_next = S_IDLE;
                    end else if (lb_sdram_Wait) begin
                        state_next = S_WAIT;
                    end
                end else if (lb_sdram_Wait) begin
                    // Grant withdrawn before ac: back off, reissue same word.
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: request and address are held stable by the registered
    // word/base until the acknowledge arrives.
    always_comb begin
        lb_sdram_rd   = (state == S_REQ);
        lb_sdram_addr = base + 22'(word);
    end

    // Fetch datapath and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_prev <= 1'b0;
            disp_bank <= 1'b0;
            word      <= '0;
            base      <= FB_BASE;
            line      <= 10'd0;
            lb_Busy   <= 1'b0;
            lb_done   <= 1'b0;
        end else begin
            trig_prev <= (DrawX == 10'(TRIGGER_X));
            if (start) begin
                // Swapping here exposes the previously fetched line and hands
                // the other bank to the new fetch.
                disp_bank <= ~disp_bank;
                word      <= '0;
                base      <= FB_BASE + 22'(target_line) * 22'(WPL);
                line      <= target_line;
                lb_Busy   <= 1'b1;
                if (target_line == 10'd0) begin
                    lb_done <= 1'b0;
                end
            end else if (ac_hit) begin
                if (last_ac) begin
                    lb_Busy <= 1'b0;
                    if (line == 10'(V_ACTIVE - 1)) begin
                        lb_done <= 1'b1;
                    end
                end else begin
                    word <= word + WW'(1);
                end
            end
        end
    end

    // Bank b occupies entries [b*WPL, b*WPL+WPL-1]; fetch always writes the
    // bank opposite the one being displayed, so read and write never collide.
    assign wr_idx = (disp_bank ? AW'(0) : AW'(WPL)) + AW'(word);

    always_ff @(posedge clk) begin
        if (ac_hit) begin
            buf_mem[wr_idx] <= lb_sdram_data;
        end
    end

    assign visible = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
    assign rd_idx  = (disp_bank ? AW'(WPL) : AW'(0))
                   + (visible ? AW'(DrawX[9:3]) : AW'(0));
    assign rd_word = buf_mem[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_data <= 16'h0000;
        end else if (visible) begin
            pix_data <= rd_word[{DrawX[2:0], 4'b0000} +: 16];
        end else begin
            pix_data <= 16'h0000;
        end
    end

`ifdef LB_UNDERRUN_STAT_EN
    logic       drop;
    logic [7:0] urun;

    assign drop = trigger && has_target && (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            urun <= 8'h00;
        end else if (drop && (urun != 8'hFF)) begin
            urun <= urun + 8'h01;
        end
    end

    assign underrun_cnt = urun;
`else
    assign underrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_line_fetch_buffer.sv
// tb/tb_line_fetch_buffer.sv - scoreboard bench for line_fetch_buffer
`timescale 1ns/1ps

module tb_line_fetch_buffer;

    localparam logic [21:0] FB = 22'h100000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [9:0]   DrawX = 10'd0;
    logic [9:0]   DrawY = 10'd0;
    logic         lb_sdram_rd;
    logic [21:0]  lb_sdram_addr;
    logic         lb_sdram_Wait = 1'b0;
    logic         lb_sdram_ac = 1'b0;
    logic [127:0] lb_sdram_data = '0;
    logic         lb_Busy;
    logic         lb_done;
    logic [15:0]  pix_data;
    logic [7:0]   underrun_cnt;

    always #5 clk = ~clk;

    line_fetch_buffer #(.FB_BASE(FB)) dut (
        .clk           (clk),
        .reset         (reset),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .lb_sdram_rd   (lb_sdram_rd),
        .lb_sdram_addr (lb_sdram_addr),
        .lb_sdram_Wait (lb_sdram_Wait),
        .lb_sdram_ac   (lb_sdram_ac),
        .lb_sdram_data (lb_sdram_data),
        .lb_Busy       (lb_Busy),
        .lb_done       (lb_done),
        .pix_data      (pix_data),
        .underrun_cnt  (underrun_cnt)
    );

    int          n_vec = 0;
    int          n_fail = 0;
    logic [21:0] exp_q[$];
    int          total_acs = 0;
    logic [21:0] last_addr = '0;

    bit          force_wait = 1'b0;
    bit          stall_armed = 1'b0;
    logic [21:0] stall_addr = '0;
    int          stall_cnt = 0;
    bit          stall_hit = 1'b0;
    bit          rd_in_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pattern(input logic [21:0] a);
        logic [127:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i*16 +: 16] = {a[12:0], 3'(i)};
        end
        return p;
    endfunction

    // Arbiter/SDRAM responder: acks every second cycle while granting.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (force_wait) begin
                lb_sdram_Wait = 1'b1;
                lb_sdram_ac   = 1'b0;
            end else if (stall_cnt > 0) begin
                lb_sdram_Wait = 1'b1;
                lb_sdram_ac   = 1'b0;
                stall_cnt--;
                if (lb_sdram_rd) rd_in_stall = 1'b1;
            end else if (stall_armed && lb_sdram_rd && lb_sdram_addr == stall_addr) begin
                lb_sdram_Wait = 1'b1;
                lb_sdram_ac   = 1'b0;
                stall_cnt     = 2;
                stall_armed   = 1'b0;
                stall_hit     = 1'b1;
            end else begin
                lb_sdram_Wait = 1'b0;
                if (lb_sdram_rd && !lb_sdram_ac) begin
                    lb_sdram_ac   = 1'b1;
                    lb_sdram_data = pattern(lb_sdram_addr);
                end else begin
                    lb_sdram_ac = 1'b0;
                end
            end
        end
    end

    // Monitor: every acknowledged request is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (lb_sdram_rd && lb_sdram_ac) begin
                total_acs++;
                last_addr = lb_sdram_addr;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL req_unexpected: got addr %0h expected no request", lb_sdram_addr);
                end else begin
                    check("req_addr", 32'(lb_sdram_addr), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_line(input int line, input int n);
        for (int w = 0; w < n; w++) begin
            exp_q.push_back(FB + 22'(line * 80 + w));
        end
    endtask

    task automatic do_trig(input int y, input logic exp_busy);
        @(negedge clk);
        DrawY = 10'(y);
        DrawX = 10'd799;
        @(negedge clk);
        check($sformatf("busy_after_trig_y%0d", y), 32'(lb_Busy), 32'(exp_busy));
        @(negedge clk);
        DrawX = 10'd0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (lb_Busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (lb_Busy) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0 within 3000 cycles", name);
        end
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pix_check(input string name, input int x, input int y, input logic [15:0] exp);
        @(negedge clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge clk);
        check(name, 32'(pix_data), 32'(exp));
    endtask

    initial begin
        int a0;
        int t;
        logic [7:0] exp_urun;
`ifdef LB_UNDERRUN_STAT_EN
        exp_urun = 8'd1;
`else
        exp_urun = 8'd0;
`endif

        repeat (3) @(negedge clk);
        check("rst_rd", 32'(lb_sdram_rd), 32'd0);
        check("rst_addr", 32'(lb_sdram_addr), 32'(FB));
        check("rst_busy", 32'(lb_Busy), 32'd0);
        check("rst_done", 32'(lb_done), 32'd0);
        check("rst_pix", 32'(pix_data), 32'd0);
        check("rst_urun", 32'(underrun_cnt), 32'd0);
        reset = 1'b1;

        // Frame wrap: DrawY=524 fetches line 0
        a0 = total_acs;
        push_line(0, 80);
        @(negedge clk);
        DrawY = 10'd524;
        DrawX = 10'd799;
        check("busy_on_trig_edge", 32'(lb_Busy), 32'd0);
        @(negedge clk);
        check("busy_1clk_after", 32'(lb_Busy), 32'd1);
        @(negedge clk);
        DrawX = 10'd0;
        wait_idle("fetch_l0");
        check("acs_l0", 32'(total_acs - a0), 32'd80);
        check("done_l0", 32'(lb_done), 32'd0);

        // Line 10 at FB 0x100000
        a0 = total_acs;
        push_line(10, 80);
        do_trig(9, 1'b1);
        wait_idle("fetch_l10");
        check("last_addr_l10", 32'(last_addr), 32'h0010036F);
        check("acs_l10", 32'(total_acs - a0), 32'd80);
        pix_check("pix_l0_x42", 42, 9, 16'h002A);

        // Line 11 with a 3-cycle grant loss at word 37; line 10 now displayed
        stall_addr  = 22'h100395;
        stall_armed = 1'b1;
        a0 = total_acs;
        push_line(11, 80);
        do_trig(10, 1'b1);
        pix_check("pix_l10_x42", 42, 10, 16'h192A);
        pix_check("pix_l10_x639", 639, 10, 16'h1B7F);
        pix_check("pix_x640_blank", 640, 10, 16'h0000);
        pix_check("pix_y480_blank", 42, 480, 16'h0000);
        wait_idle("fetch_l11");
        check("stall_seen", 32'(stall_hit), 32'd1);
        check("rd_dropped_in_stall", 32'(rd_in_stall), 32'd0);
        check("acs_l11", 32'(total_acs - a0), 32'd80);

        // Last visible line sets done; holds through blanking
        push_line(479, 80);
        do_trig(478, 1'b1);
        wait_idle("fetch_l479");
        check("done_after_l479", 32'(lb_done), 32'd1);
        do_trig(479, 1'b0);
        check("done_hold_y479", 32'(lb_done), 32'd1);
        do_trig(523, 1'b0);
        check("done_hold_y523", 32'(lb_done), 32'd1);
        push_line(0, 80);
        @(negedge clk);
        DrawY = 10'd524;
        DrawX = 10'd799;
        check("done_before_clear", 32'(lb_done), 32'd1);
        @(negedge clk);
        check("done_cleared", 32'(lb_done), 32'd0);
        @(negedge clk);
        DrawX = 10'd0;
        wait_idle("fetch_l0b");
        check("done_after_l0b", 32'(lb_done), 32'd0);

        // Underrun: grant withheld across two triggers
        force_wait = 1'b1;
        a0 = total_acs;
        push_line(6, 80);
        do_trig(5, 1'b1);
        pix_check("pix_y5_x42", 42, 5, 16'h002A);
        do_trig(6, 1'b1);
        check("urun_cnt", 32'(underrun_cnt), 32'(exp_urun));
        pix_check("pix_y6_repeat", 42, 6, 16'h002A);
        force_wait = 1'b0;
        wait_idle("fetch_l6");
        check("acs_l6", 32'(total_acs - a0), 32'd80);

        // Asynchronous reset mid-fetch at word 40
        a0 = total_acs;
        push_line(21, 40);
        do_trig(20, 1'b1);
        t = 0;
        while ((total_acs - a0) < 40 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("acs_before_rst", 32'(total_acs - a0), 32'd40);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_rd", 32'(lb_sdram_rd), 32'd0);
        check("arst_busy", 32'(lb_Busy), 32'd0);
        check("arst_done", 32'(lb_done), 32'd0);
        check("arst_addr", 32'(lb_sdram_addr), 32'(FB));
        check("arst_urun", 32'(underrun_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rst_queue_left", 32'(exp_q.size()), 32'd0);
        a0 = total_acs;
        push_line(21, 80);
        do_trig(20, 1'b1);
        wait_idle("fetch_l21");
        check("acs_l21", 32'(total_acs - a0), 32'd80);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
